// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: hazard inputs from ID/EX/MEM and per-stage hold/flush controls back.
// master = pipeline side (drives hazard inputs); slave = the controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_wr_addr;
  logic        ex_branch_taken;
  logic        md_start;
  logic        mem_req;
  logic        mem_ack;

  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_stall;
  logic        exmem_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_bubble;
  logic        md_done;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, ex_mem_read, ex_wr_addr,
           ex_branch_taken, md_start, mem_req, mem_ack,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
           exmem_flush, memwb_bubble, md_done, ctrl_state, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, ex_mem_read, ex_wr_addr,
           ex_branch_taken, md_start, mem_req, mem_ack,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
           exmem_flush, memwb_bubble, md_done, ctrl_state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: Mealy controls act in the same cycle as the hazard; mult/div holds EX MD_LATENCY cycles.
// No backpressure of its own; memory wait freezes everything. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 8
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, exmem_flush, memwb_bubble, md_done;
  logic rs_hit, rt_hit, load_use, mem_block;

  assign rs_hit   = bus.id_uses_rs && (bus.id_rs_addr == bus.ex_wr_addr);
  assign rt_hit   = bus.id_uses_rt && (bus.id_rt_addr == bus.ex_wr_addr);
  assign load_use = bus.ex_mem_read && (bus.ex_wr_addr != 5'd0) && (rs_hit || rt_hit);
  // In MEM_WAIT the access is already outstanding, so only the ack matters.
  assign mem_block = (state_q == RUN) ? (bus.mem_req && !bus.mem_ack) : !bus.mem_ack;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    md_done      = 1'b0;
    if (rst) begin
      case (state_q)
        RUN, MEM_WAIT: begin
          state_d = RUN;
          if (mem_block) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
            state_d      = MEM_WAIT;
          end else if (bus.md_start) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = MD_BUSY;
            cnt_d       = 6'(MD_LATENCY - 1);
          end else if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt_q != 6'd0) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
            cnt_d       = cnt_q - 6'd1;
          end else begin
            md_done = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.ifid_stall   = ifid_stall;
  assign bus.idex_stall   = idex_stall;
  assign bus.exmem_stall  = exmem_stall;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.md_done      = md_done;
  assign bus.ctrl_state   = rst ? state_q : RUN;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (idex_flush || exmem_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cycles = rst ? stall_cnt_q : 32'd0;
  assign bus.flush_count  = rst ? flush_cnt_q : 32'd0;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int MDL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.MD_LATENCY(MDL)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0]  ctl;   // pc,ifid,idex,exmem stall | ifid,idex,exmem flush | memwb bubble
    logic        done;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: mode 0=running, 1=waiting on memory, 2=mult/div in flight until md_done_at.
  int          m_mode = 0;
  int          md_done_at = 0;
  int unsigned m_sc = 0;
  int unsigned m_fc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("controls", 32'({bus.pc_stall, bus.ifid_stall, bus.idex_stall, bus.exmem_stall,
                             bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_bubble}),
            32'(mon_e.ctl));
      check("md_done", 32'(bus.md_done), 32'(mon_e.done));
      check("ctrl_state", 32'(bus.ctrl_state), 32'(mon_e.st));
      check("stall_cycles", bus.stall_cycles, mon_e.sc);
      check("flush_count", bus.flush_count, mon_e.fc);
    end
  end

  task automatic drv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic us, input logic ut, input logic lr, input logic [4:0] wr,
                     input logic br, input logic ms, input logic mr, input logic ma);
    exp_t e;
    logic blocked, hazard;
    @(posedge clk);
    #1;
    rst = r;
    bus.id_rs_addr = rs; bus.id_rt_addr = rt;
    bus.id_uses_rs = us; bus.id_uses_rt = ut;
    bus.ex_mem_read = lr; bus.ex_wr_addr = wr;
    bus.ex_branch_taken = br; bus.md_start = ms;
    bus.mem_req = mr; bus.mem_ack = ma;

    e = '0;
    if (!r) begin
      m_mode = 0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      e.st = 2'(m_mode);
      e.sc = m_sc;
      e.fc = m_fc;
      if (m_mode == 2) begin
        if (cyc < md_done_at) e.ctl = 8'b1110_0010;
        else begin e.done = 1'b1; m_mode = 0; end
      end else begin
        blocked = (m_mode == 0) ? (mr && !ma) : !ma;
        hazard  = lr && (wr != 0) && ((us && rs == wr) || (ut && rt == wr));
        if (blocked) begin
          e.ctl = 8'b1111_0001; m_mode = 1;
        end else begin
          m_mode = 0;
          if (ms) begin
            e.ctl = 8'b1110_0010; m_mode = 2; md_done_at = cyc + MDL;
          end else if (br) e.ctl = 8'b0000_1100;
          else if (hazard) e.ctl = 8'b1100_0100;
        end
      end
      if (e.ctl[7]) m_sc++;
      if (e.ctl[2] || e.ctl[1]) m_fc++;
    end
`ifndef PIPE_CTRL_PERF_EN
    e.sc = 0;
    e.fc = 0;
`endif
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Load-use on $5, then same shape with $0 (no hazard)
    drv(1, 5, 1, 1, 0, 1, 5, 0, 0, 0, 0);
    idle(1);
    drv(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    // rt-side hazard, then branch coinciding with load-use
    drv(1, 2, 7, 1, 1, 1, 7, 0, 0, 0, 0);
    drv(1, 5, 1, 1, 0, 1, 5, 1, 0, 0, 0);
    idle(1);
    // Memory wait: 3 cycles no ack, then ack
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    idle(2);
    // Mult/div issue with everything else asserted (ignored while busy)
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < MDL - 1; i++) drv(1, 3, 0, 1, 0, 1, 3, 1, 1, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Ack arriving with a mult frozen in EX
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(MDL + 1);
    // Reset mid mult/div
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(MDL + 2);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drv(($urandom_range(63) != 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
          1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(3)),
          ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          ($urandom_range(2) == 0), 1'($urandom));
    end
    idle(1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Combines load-use hazard detection, taken-branch flushing, data-memory wait handshaking and multi-cycle mult/div sequencing into per-stage hold/flush controls. These controls drive PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sits beside the pipeline registers and is the only source of their stall/flush inputs.

## Interface
- MD_LATENCY, 8, mult/div execution cycles; legal range 1..63; 6-bit down-counter.
- clk  in  1  pipeline clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- id_rs_addr, id_rt_addr  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_wr_addr  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken.
- md_start  in  1  instruction in EX is mult/div.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ack  in  1  data memory completes the access this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the register.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all controls 0).
- memwb_bubble  out  1  MEM/WB captures RegWE=0.
- md_done  out  1  mult/div result valid; EX releases this cycle.
- ctrl_state  out  2  0=RUN, 1=MEM_WAIT, 2=MD_BUSY.
- stall_cycles, flush_count  out  32 each  performance counters (see Configuration).

## Operation
Outputs are combinational from state and inputs (Mealy), so a stall acts in the cycle it is detected. State, the counter and the perf counters are registered.

- **Reset**
  - rst=0: state→RUN, md counter→0, perf counters→0.
  - While rst=0 every output is 0 and ctrl_state=0.
- **RUN**: evaluate in strict priority order.
  1. mem_req=1 and mem_ack=0: full stall.
     - pc/ifid/idex/exmem_stall=1 and memwb_bubble=1.
     - All flushes 0; the branch is deferred because EX is frozen.
     - Next state MEM_WAIT.
  2. md_start=1: pc/ifid/idex_stall=1, exmem_flush=1. Next state MD_BUSY; counter←MD_LATENCY-1.
  3. ex_branch_taken=1: ifid_flush=1, idex_flush=1. PC not stalled.
  4. Load-use: all of the following hold.
     - ex_mem_read=1.
     - ex_wr_addr≠0.
     - (id_uses_rs and id_rs_addr==ex_wr_addr) or (id_uses_rt and id_rt_addr==ex_wr_addr).
     - Response: pc_stall=1, ifid_stall=1, idex_flush=1.
  5. Otherwise all controls 0.
- **MEM_WAIT**
  - mem_ack=0: same outputs as RUN rule 1; stay.
  - mem_ack=1: outputs and next state are exactly those of RUN evaluated with mem_req treated as 0. A mult/div frozen in EX therefore enters MD_BUSY directly.
- **MD_BUSY**
  - Counter≠0: pc/ifid/idex_stall=1, exmem_flush=1; counter decrements.
  - Counter==0: md_done=1 and all controls 0 (EX advances). Next state RUN.
  - md_start, mem_req, ex_branch_taken and load-use are ignored while in MD_BUSY. MEM holds a bubble.
- Register $0 never triggers load-use.

## Timing
- Stall/flush latency: 0 cycles (same cycle as the causing inputs).
- Mult/div issued in RUN at cycle t:
  - Stalled cycles t..t+MD_LATENCY-1.
  - md_done at t+MD_LATENCY.
  - EX occupancy MD_LATENCY+1 cycles.
  - MD_LATENCY=1: md_done at t+1.
- Memory wait: stall every cycle mem_ack=0. Release in the cycle mem_ack=1. Minimum MEM_WAIT residency 1 cycle.
- Load-use: exactly one bubble per hazard; the next cycle re-evaluates against the new EX instruction.
- Reset has priority over every state and input. Reset mid-MD_BUSY or mid-MEM_WAIT returns to RUN on the next edge with the counter cleared.

## Configuration
- **PIPE_CTRL_PERF_EN defined**
  - stall_cycles increments every cycle pc_stall=1.
  - flush_count increments every cycle idex_flush=1 or exmem_flush=1.
  - Both wrap modulo 2^32 and clear on reset.
- **Not defined**: both ports present, tied to 0; no counter flops.

## Test plan
- Load-use: EX load writes $5 (ex_mem_read=1), ID reads rs=$5 (id_uses_rs=1) → one cycle pc_stall=ifid_stall=idex_flush=1, then all 0. Repeat with ex_wr_addr=0 → no stall.
- Branch and load-use simultaneous: ex_branch_taken=1 plus a load-use match → ifid_flush=idex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, mem_ack low 3 cycles then high → 3 cycles of full stall with memwb_bubble=1 and ctrl_state=1, then 0 stalls on the ack cycle and ctrl_state=0 next.
- Mult/div, MD_LATENCY=4: md_start at cycle 10 → stall cycles 10–13, md_done=1 at 14, ctrl_state=0 at 15. With PIPE_CTRL_PERF_EN, stall_cycles=4 and flush_count=4.
- Ack with mult frozen: MEM_WAIT, mem_ack=1 and md_start=1 → exmem_stall=0, exmem_flush=1, next ctrl_state=2.
- Reset mid-MD_BUSY (counter=3): rst=0 for one edge → all outputs 0 during reset; ctrl_state=0 and md_done never asserts afterwards.
